// File: rtl/wb_trace_buffer_if.sv
// Signal bundle between the pipeline debug taps / drainer (master) and wb_trace_buffer (slave).
interface wb_trace_buffer_if #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]     in_PC;
    logic [31:0]     in_write_data;
    logic            Capture_En;
    logic            Clear_Overflow;
    logic            Out_Ready;
    logic            Out_Valid;
    logic [31:0]     Out_PC;
    logic [31:0]     Out_Data;
    logic [TS_W-1:0] Out_Stamp;
    logic [CW-1:0]   Count;
    logic            Full;
    logic            Empty;
    logic            Overflow;
    logic [15:0]     Drop_Count;

    modport master (
        output in_PC, in_write_data, Capture_En, Clear_Overflow, Out_Ready,
        input  Out_Valid, Out_PC, Out_Data, Out_Stamp, Count, Full, Empty,
               Overflow, Drop_Count
    );

    modport slave (
        input  in_PC, in_write_data, Capture_En, Clear_Overflow, Out_Ready,
        output Out_Valid, Out_PC, Out_Data, Out_Stamp, Count, Full, Empty,
               Overflow, Drop_Count
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Timestamped write-back trace FIFO; captures pipeline debug events without back-pressuring the core.
module wb_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter bit FILTER_ZERO = 1'b1
) (
    input logic              Clk,
    input logic              Reset,
    wb_trace_buffer_if.slave bus
);
    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     data;
        logic [TS_W-1:0] stamp;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TS_W-1:0] stamp;
    logic            overflow;
    logic [15:0]     drop_count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            accept;
    logic            drop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        full   = (count == FULL_COUNT);
        empty  = (count == '0);
        push   = bus.Capture_En && (!FILTER_ZERO || (bus.in_write_data != '0));
        pop    = !empty && bus.Out_Ready;
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    // NOTE: storage is deliberately left out of reset; the head mux masks stale contents while empty.
    always_ff @(posedge Clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{pc: bus.in_PC, data: bus.in_write_data, stamp: stamp};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stamp      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            stamp <= stamp + 1'b1;

            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end

            // Clear beats a drop landing in the same cycle.
            if (bus.Clear_Overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    assign head = mem[rd_ptr];

    assign bus.Out_Valid  = !empty;
    assign bus.Out_PC     = empty ? '0 : head.pc;
    assign bus.Out_Data   = empty ? '0 : head.data;
    assign bus.Out_Stamp  = empty ? '0 : head.stamp;
    assign bus.Count      = count;
    assign bus.Full       = full;
    assign bus.Empty      = empty;
    assign bus.Overflow   = overflow;
    assign bus.Drop_Count = drop_count;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    wb_trace_buffer_if #(.DEPTH(DEPTH), .TS_W(TS_W)) bus ();

    wb_trace_buffer #(
        .DEPTH      (DEPTH),
        .TS_W       (TS_W),
        .FILTER_ZERO(1'b1)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [15:0] stamp;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_stamp;
    logic [15:0] m_drops;
    logic        m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic drive(input logic cap, input logic [31:0] pc, input logic [31:0] data,
                         input logic rdy, input logic clr);
        bus.Capture_En     = cap;
        bus.in_PC          = pc;
        bus.in_write_data  = data;
        bus.Out_Ready      = rdy;
        bus.Clear_Overflow = clr;
    endtask

    // Advance the reference model by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        bit push, pop, full, dropped;
        push    = bus.Capture_En && (bus.in_write_data != 32'd0);
        pop     = (q.size() != 0) && bus.Out_Ready;
        full    = (q.size() == DEPTH);
        dropped = push && full && !pop;
        if (Reset) begin
            q.delete();
            m_stamp = '0;
            m_ovf   = 1'b0;
            m_drops = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push && !dropped) q.push_back('{bus.in_PC, bus.in_write_data, m_stamp});
            if (bus.Clear_Overflow) begin
                m_ovf   = 1'b0;
                m_drops = '0;
            end else if (dropped) begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end
            m_stamp = m_stamp + 16'd1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.Out_Valid); end
        n_checks++;
        if (bus.Empty !== 1'b1 || bus.Full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", bus.Empty, bus.Full);
        end
        n_checks++;
        if (bus.Count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.Count); end
        n_checks++;
        if (bus.Overflow !== 1'b0 || bus.Drop_Count !== 16'd0) begin
            n_fail++; $display("FAIL reset_overflow: ovf=%b drops=%0d want 0/0", bus.Overflow, bus.Drop_Count);
        end
        n_checks++;
        if (bus.Out_PC !== 32'd0 || bus.Out_Data !== 32'd0 || bus.Out_Stamp !== 16'd0) begin
            n_fail++; $display("FAIL reset_head: pc=%h data=%h stamp=%h want zeros", bus.Out_PC, bus.Out_Data, bus.Out_Stamp);
        end
    endtask

    task automatic test_filter_zero();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, 32'd0, 1'b0, 1'b0);
            tick();
            n_checks++;
            if (bus.Empty !== 1'b1 || bus.Count !== '0) begin
                n_fail++; $display("FAIL filter_zero_c%0d: empty=%b count=%0d want 1/0", i, bus.Empty, bus.Count);
            end
        end
        drive(1'b1, 32'h100, 32'h55, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.Out_Valid !== 1'b1 || bus.Out_Stamp !== 16'd5) begin
            n_fail++; $display("FAIL filter_stamp: valid=%b stamp=%0d want 1/5", bus.Out_Valid, bus.Out_Stamp);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_single_push();
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        drive(1'b1, 32'h4, 32'hA, 1'b0, 1'b0);
        n_checks++;
        if (bus.Out_Valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: valid=%b want 0", bus.Out_Valid); end
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_checks++;
        if (bus.Out_Valid !== 1'b1 || bus.Out_PC !== 32'h4 || bus.Out_Data !== 32'hA ||
            bus.Out_Stamp !== 16'd3 || bus.Count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_head: valid=%b pc=%h data=%h stamp=%0d count=%0d want 1/4/a/3/1",
                     bus.Out_Valid, bus.Out_PC, bus.Out_Data, bus.Out_Stamp, bus.Count);
        end
        tick();
        n_checks++;
        if (bus.Out_PC !== 32'h4 || bus.Count !== 5'd1) begin
            n_fail++; $display("FAIL single_hold: pc=%h count=%0d want 4/1", bus.Out_PC, bus.Count);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (bus.Empty !== 1'b1) begin n_fail++; $display("FAIL single_pop: empty=%b want 1", bus.Empty); end
    endtask

    task automatic test_fill_overflow();
        ent_t first;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, $urandom, $urandom | 32'd1, 1'b0, 1'b0);
            tick();
            if (i == 0) first = q[0];
        end
        n_checks++;
        if (bus.Full !== 1'b1 || bus.Count !== 5'd16 || bus.Empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: full=%b count=%0d empty=%b want 1/16/0", bus.Full, bus.Count, bus.Empty);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom | 32'd1, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (bus.Overflow !== 1'b1 || bus.Drop_Count !== 16'd3) begin
            n_fail++; $display("FAIL fill_drops: ovf=%b drops=%0d want 1/3", bus.Overflow, bus.Drop_Count);
        end
        n_checks++;
        if (bus.Out_PC !== first.pc || bus.Out_Data !== first.data || bus.Out_Stamp !== 16'd0) begin
            n_fail++; $display("FAIL fill_head: pc=%h data=%h stamp=%0d want %h/%h/0",
                               bus.Out_PC, bus.Out_Data, bus.Out_Stamp, first.pc, first.data);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] last_pc;
        drive(1'b1, 32'hCAFE_0000, 32'h0000_BEEF, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (bus.Count !== 5'd16 || bus.Full !== 1'b1 || bus.Drop_Count !== 16'd3) begin
            n_fail++; $display("FAIL fullpp_state: count=%0d full=%b drops=%0d want 16/1/3", bus.Count, bus.Full, bus.Drop_Count);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        last_pc = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (q.size() == 0 || bus.Out_PC !== q[0].pc || bus.Out_Data !== q[0].data || bus.Out_Stamp !== q[0].stamp) begin
                n_fail++; $display("FAIL drain_order_%0d: pc=%h data=%h stamp=%0d", i, bus.Out_PC, bus.Out_Data, bus.Out_Stamp);
            end
            last_pc = bus.Out_PC;
            tick();
        end
        n_checks++;
        if (last_pc !== 32'hCAFE_0000 || bus.Empty !== 1'b1) begin
            n_fail++; $display("FAIL drain_last: pc=%h empty=%b want cafe0000/1", last_pc, bus.Empty);
        end
    endtask

    task automatic test_clear_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, $urandom, $urandom | 32'd1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h1234, 32'h5678, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h1235, 32'h5679, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (bus.Overflow !== 1'b0 || bus.Drop_Count !== 16'd0 || bus.Count !== 5'd16) begin
            n_fail++; $display("FAIL clear_wins: ovf=%b drops=%0d count=%0d want 0/0/16", bus.Overflow, bus.Drop_Count, bus.Count);
        end
        drive(1'b1, 32'h9, 32'h9, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) tick();
        n_checks++;
        if (bus.Drop_Count !== 16'hFFFF || bus.Overflow !== 1'b1) begin
            n_fail++; $display("FAIL drop_saturate: drops=%h ovf=%b want ffff/1", bus.Drop_Count, bus.Overflow);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b1, $urandom, $urandom | 32'd1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        n_checks++;
        if (bus.Count !== 5'd7 || bus.Overflow !== 1'b1) begin
            n_fail++; $display("FAIL middrain_pre: count=%0d ovf=%b want 7/1", bus.Count, bus.Overflow);
        end
        drive(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_checks++;
        if (bus.Count !== '0 || bus.Out_Valid !== 1'b0 || bus.Overflow !== 1'b0 || bus.Drop_Count !== 16'd0) begin
            n_fail++; $display("FAIL middrain_reset: count=%0d valid=%b ovf=%b drops=%0d want 0/0/0/0",
                               bus.Count, bus.Out_Valid, bus.Overflow, bus.Drop_Count);
        end
        drive(1'b1, 32'h40, 32'h77, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.Out_Stamp !== 16'd0 || bus.Out_PC !== 32'h40 || bus.Count !== 5'd1) begin
            n_fail++; $display("FAIL middrain_stamp: stamp=%0d pc=%h count=%0d want 0/40/1", bus.Out_Stamp, bus.Out_PC, bus.Count);
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] exp_cnt;
        logic [31:0]   exp_pc, exp_data;
        logic [15:0]   exp_stamp;
        logic          rdy;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            // Alternate slow- and fast-drain phases so the FIFO reaches both full and empty.
            rdy = ((i / 150) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  rdy, $urandom_range(0, 60) == 0);
            tick();
            exp_cnt   = CW'(q.size());
            exp_pc    = (q.size() != 0) ? q[0].pc : 32'd0;
            exp_data  = (q.size() != 0) ? q[0].data : 32'd0;
            exp_stamp = (q.size() != 0) ? q[0].stamp : 16'd0;
            n_checks++;
            if (bus.Count !== exp_cnt || bus.Empty !== (q.size() == 0) || bus.Full !== (q.size() == DEPTH) ||
                bus.Out_Valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rand_occ_%0d: count=%0d empty=%b full=%b valid=%b want count %0d",
                                   i, bus.Count, bus.Empty, bus.Full, bus.Out_Valid, exp_cnt);
            end
            n_checks++;
            if (bus.Out_PC !== exp_pc || bus.Out_Data !== exp_data || bus.Out_Stamp !== exp_stamp) begin
                n_fail++; $display("FAIL rand_head_%0d: pc=%h data=%h stamp=%h want %h/%h/%h",
                                   i, bus.Out_PC, bus.Out_Data, bus.Out_Stamp, exp_pc, exp_data, exp_stamp);
            end
            n_checks++;
            if (bus.Overflow !== m_ovf || bus.Drop_Count !== m_drops) begin
                n_fail++; $display("FAIL rand_ovf_%0d: ovf=%b drops=%0d want %b/%0d",
                                   i, bus.Overflow, bus.Drop_Count, m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        test_reset();
        test_filter_zero();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_clear_overflow();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Downstream consumer of the processor's debug outputs (current fetch PC, write-back data).
- Each cycle it timestamps and captures qualifying write-back events into a small FIFO, which a display or UART drainer empties via a valid/ready handshake.
- Gives board-level observability of the 5-stage pipeline without stalling it; the processor never sees back-pressure.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- TS_W, 16, width of the free-running cycle stamp.
- FILTER_ZERO, 1, when 1, cycles with in_write_data == 0 are not captured; when 0, every enabled cycle is captured.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_PC  input  32  processor fetch PC for the current cycle.
- in_write_data  input  32  processor write-back data; zero when no register write.
- Capture_En  input  1  capture enable; level-sensitive.
- Clear_Overflow  input  1  clears Overflow and Drop_Count.
- Out_Ready  input  1  consumer accepts the head entry.
- Out_Valid  output  1  FIFO non-empty; head entry presented.
- Out_PC  output  32  head entry PC.
- Out_Data  output  32  head entry write data.
- Out_Stamp  output  TS_W  head entry cycle stamp.
- Count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- Overflow  output  1  sticky; an entry was dropped.
- Drop_Count  output  16  saturating count of dropped entries.

Behaviour:
- Reset (synchronous, on a Clk edge with Reset = 1):
  - Write/read pointers, Count, stamp counter, Overflow and Drop_Count all go to 0.
  - Out_Valid = 0, Empty = 1, Full = 0.
  - Out_PC, Out_Data and Out_Stamp read 0 while empty after reset; storage contents need not be cleared.
  - Reset mid-drain discards all entries, and Reset has priority over every other input.
- Stamp counter:
  - Increments by 1 every non-reset cycle and wraps from 2^TS_W-1 to 0.
  - The stamp stored with an entry is the counter value in the capture cycle.
- push = Capture_En & (FILTER_ZERO == 0 | in_write_data != 0).
- pop = Out_Valid & Out_Ready.
- Accept rule: push is accepted if !Full or pop is asserted in the same cycle. A full FIFO with a simultaneous pop accepts the push, and Count stays at DEPTH.
- Accepted push: {in_PC, in_write_data, stamp} is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Pop: rd_ptr advances modulo DEPTH.
- Count update:
  - +1 for accepted push only.
  - -1 for pop only.
  - Unchanged for both or neither.
- Latency: an entry pushed at edge N is visible on the Out_* ports after edge N; Out_Valid rises after that edge. There is no same-cycle bypass from the inputs, so pushing while empty does not raise Out_Valid in the same cycle.
- Head presentation:
  - Out_PC, Out_Data and Out_Stamp are driven from storage[rd_ptr], combinational from registered state.
  - They hold stable while Out_Valid = 1 and Out_Ready = 0.
- Pop with Empty: impossible by construction (Out_Valid = 0); Out_Ready is ignored.
- Dropped push (push while Full and no pop):
  - Entry is discarded and Overflow is set.
  - Drop_Count increments and saturates at 16'hFFFF.
  - Pointers and stored data are unchanged.
- Clear_Overflow:
  - Zeroes Overflow and Drop_Count on the next edge.
  - If a drop occurs in the same cycle, clear wins: both end at 0.
- Full, Empty and Count are registered-derived and consistent with each other in every cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; Count distinguishes full from empty.

Test Plan:
- Reset, then Capture_En = 1, FILTER_ZERO = 1, in_write_data = 0 for 5 cycles -> Empty stays 1, Count = 0, and the stamp counter reaches 5.
- After reset, push PC = 0x4, data = 0xA at stamp 3, with Out_Ready = 0 -> the next cycle shows Out_Valid = 1, Out_PC = 0x4, Out_Data = 0xA, Out_Stamp = 3, Count = 1; one cycle with Out_Ready = 1 -> Empty = 1.
- Push 16 nonzero entries (DEPTH = 16) with Out_Ready = 0 -> Full = 1, Count = 16; push 3 more -> Overflow = 1, Drop_Count = 3, and the head is still the first entry.
- While Full, push and pop in the same cycle -> Count stays 16, the new entry is accepted, and Drop_Count is unchanged; drain all entries -> order is FIFO and the last entry is the one pushed during full+pop.
- Assert Clear_Overflow in the same cycle as a drop -> Overflow = 0, Drop_Count = 0; then force 70000 drops -> Drop_Count = 0xFFFF.
- Reset asserted with Count = 7 mid-drain -> the next cycle shows Count = 0, Out_Valid = 0, stamp = 0, Overflow = 0.
